// File: rtl/plab4_net_domain_merge.sv
// Merges two 2-entry-buffered message lanes onto one registered output link,
// round-robin between lanes with a one-cycle bubble whenever the domain switches.
module plab4_net_domain_merge_fifo #(
    parameter int W = 76
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enq,
    input  logic         deq,
    input  logic [W-1:0] enq_msg,
    output logic         rdy,
    output logic         nonempty,
    output logic [W-1:0] head
);
    logic [1:0][W-1:0] mem;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;

    assign rdy      = (count != 2'd2);
    assign nonempty = (count != 2'd0);
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (enq) begin
                mem[wr_ptr] <= enq_msg;
                wr_ptr      <= ~wr_ptr;
            end
            if (deq) rd_ptr <= ~rd_ptr;
            count <= count + 2'(enq) - 2'(deq);
        end
    end
endmodule

module plab4_net_domain_merge #(
    parameter int p_msg_cnbits = 44,
    parameter int p_msg_dnbits = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_val_d1,
    output logic                    in_rdy_d1,
    input  logic [p_msg_cnbits-1:0] in_msg_control_d1,
    input  logic [p_msg_dnbits-1:0] in_msg_data_d1,
    input  logic                    in_val_d2,
    output logic                    in_rdy_d2,
    input  logic [p_msg_cnbits-1:0] in_msg_control_d2,
    input  logic [p_msg_dnbits-1:0] in_msg_data_d2,
    output logic                    out_val,
    input  logic                    out_rdy,
    output logic [p_msg_cnbits-1:0] out_msg_control,
    output logic [p_msg_dnbits-1:0] out_msg_data,
    output logic                    domain
);
    localparam int W = p_msg_cnbits + p_msg_dnbits;

    typedef enum logic [1:0] {IDLE, SEND, SCRUB} state_t;

    state_t            state;
    logic              ptr;
    logic              pending;
    logic [1:0]        in_val;
    logic [1:0]        in_rdy;
    logic [1:0]        enq;
    logic [1:0]        deq;
    logic [1:0]        nonempty;
    logic [1:0][W-1:0] in_msg;
    logic [1:0][W-1:0] head;
    logic              decide;
    logic              win_vld;
    logic              winner;

    assign in_val    = {in_val_d2, in_val_d1};
    assign in_msg[0] = {in_msg_control_d1, in_msg_data_d1};
    assign in_msg[1] = {in_msg_control_d2, in_msg_data_d2};
    assign in_rdy_d1 = in_rdy[0];
    assign in_rdy_d2 = in_rdy[1];
    assign enq       = in_val & in_rdy;

    for (genvar i = 0; i < 2; i++) begin : g_lane
        plab4_net_domain_merge_fifo #(.W(W)) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .enq      (enq[i]),
            .deq      (deq[i]),
            .enq_msg  (in_msg[i]),
            .rdy      (in_rdy[i]),
            .nonempty (nonempty[i]),
            .head     (head[i])
        );
    end

    // Pointer only breaks ties; a lone non-empty lane always wins.
    always_comb begin
        decide  = (state == IDLE) || (state == SEND && out_rdy);
        win_vld = |nonempty;
        winner  = (&nonempty) ? ptr : nonempty[1];
        deq     = 2'b00;
        if (state == SCRUB)
            deq[pending] = 1'b1;
        else if (decide && win_vld && winner == domain)
            deq[winner] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            ptr             <= 1'b0;
            pending         <= 1'b0;
            domain          <= 1'b0;
            out_val         <= 1'b0;
            out_msg_control <= '0;
            out_msg_data    <= '0;
        end else if (state == SCRUB) begin
            state                           <= SEND;
            out_val                         <= 1'b1;
            {out_msg_control, out_msg_data} <= head[pending];
            ptr                             <= ~pending;
        end else if (decide) begin
            if (win_vld && winner == domain) begin
                state                           <= SEND;
                out_val                         <= 1'b1;
                {out_msg_control, out_msg_data} <= head[winner];
                ptr                             <= ~winner;
            end else begin
                // Switching domain (or nothing to send): blank the link this cycle.
                state           <= win_vld ? SCRUB : IDLE;
                out_val         <= 1'b0;
                out_msg_control <= '0;
                out_msg_data    <= '0;
                if (win_vld) begin
                    pending <= winner;
                    domain  <= winner;
                end
            end
        end
    end
endmodule

// File: doc/plab4_net_domain_merge.md
PLAB4_NET_DOMAIN_MERGE -- requirements
Module: plab4_net_domain_merge

Interface
REQ-001 SHALL have parameter p_msg_cnbits, default 44, control message width.
REQ-002 SHALL have parameter p_msg_dnbits, default 32, data payload width.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low: reset==0 clears all state immediately; release is synchronous to clk.
REQ-005 SHALL have ports in_val_d1 input 1, in_rdy_d1 output 1, in_msg_control_d1 input p_msg_cnbits, in_msg_data_d1 input p_msg_dnbits: domain-1 lane.
REQ-006 SHALL have ports in_val_d2, in_rdy_d2, in_msg_control_d2, in_msg_data_d2, same widths: domain-2 lane.
REQ-007 SHALL have ports out_val output 1, out_rdy input 1, out_msg_control output p_msg_cnbits, out_msg_data output p_msg_dnbits: merged link.
REQ-008 SHALL have port domain, output, 1, lane of current output message (0 = d1, 1 = d2).

Function
REQ-009 SHALL provide one 2-entry FIFO per lane storing {control,data}; in_rdy_dX = FIFO not full.
REQ-010 SHALL enqueue on lane X on any edge with in_val_dX && in_rdy_dX; both lanes may enqueue the same edge.
REQ-011 SHALL allow simultaneous enqueue and dequeue on a full FIFO only if in_rdy was high that cycle (no bypass; full FIFO deasserts in_rdy).
REQ-012 SHALL drive out_val, out_msg_control, out_msg_data, domain from registers only (no combinational path from inputs or out_rdy).
REQ-013 SHALL arbitrate round-robin: priority pointer resets to d1; after each load from lane X the pointer moves to the other lane; a non-empty lane wins if the other is empty.
REQ-014 SHALL implement FSM states IDLE (out_val=0), SEND (out_val=1), SCRUB (out_val=0, one-cycle domain-switch bubble).
REQ-015 IDLE: winner W exists and W==domain -> load head of W, go SEND; W!=domain -> latch W as pending, set domain=W, go SCRUB; no winner -> stay IDLE.
REQ-016 SCRUB: unconditionally load head of pending lane, go SEND (exactly one bubble cycle); arrivals during SCRUB do not change pending lane.
REQ-017 SEND without out_rdy: hold all outputs stable, no dequeue.
REQ-018 SEND with out_rdy: same decision as IDLE (load -> stay SEND, mismatch -> SCRUB, none -> IDLE); back-to-back same-domain messages give one message per cycle.
REQ-019 SHALL drive out_msg_control and out_msg_data to all zeros whenever out_val=0 (IDLE, SCRUB); domain holds its last value in IDLE.
REQ-020 Minimum latency: message enqueued at edge E appears with out_val=1 after edge E+1 (same domain) or E+2 (domain switch).
REQ-021 SHALL preserve per-lane order; no message dropped or duplicated under any out_rdy pattern.

Reset
REQ-022 On reset==0: FIFOs empty, in_rdy_d1=in_rdy_d2=1 (once reset==1), out_val=0, outputs data/control=0, domain=0, FSM=IDLE, pointer=d1, pending=d1.
REQ-023 Reset asserted mid-transfer SHALL discard all buffered and in-flight messages with no partial output.

Verification
REQ-024 Reset release, d1 sends control=0x5 data=0xAAAA5555 at edge 1, out_rdy=1 -> out_val=1, data=0xAAAA5555, domain=0 after edge 2.
REQ-025 Reset, d2 sends data=0x12345678 at edge 1 -> SCRUB cycle (out_val=0, data=0) after edge 2, out_val=1, domain=1, data=0x12345678 after edge 3.
REQ-026 Both lanes send 2 messages same edges (d1: 0x11,0x12; d2: 0x21,0x22), out_rdy=1 -> output order 0x11, bubble, 0x21, bubble, 0x12, bubble, 0x22.
REQ-027 out_rdy=0 with 3 messages offered on d1 -> first reaches output register, FIFO holds 2, in_rdy_d1=0; output stable; raising out_rdy drains all 3 in order, one per cycle.
REQ-028 reset=0 asserted while out_val=1 and FIFOs full -> out_val=0, data=0, domain=0 immediately, no further outputs after release without new input.
